datapath: RTL and testbench
===========================

Name: datapath

Overview:
- Execution stage that sits directly downstream of the processor control unit and consumes its control word: D_Addr, D_Wr, RF_s, RF_W_en, RF_Ra_addr, RF_Rb_addr, RF_W_addr and Alu_s0.
- Contains three pieces:
  - a 16x16 register file (two combinational read ports, one synchronous write port);
  - a 16-bit ALU;
  - a 256x16 data memory (combinational read, synchronous write).
- A 2:1 mux selects the register-file write-back source.
- Registered ALU status flags are provided for future branch support.

Parameters:
- DATA_W, 16, datapath word width.
- RF_AW, 4, register-file address width (2^RF_AW registers).
- DM_AW, 8, data-memory address width (2^DM_AW words).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- D_Addr  in  DM_AW  data-memory address.
- D_Wr  in  1  data-memory write enable.
- RF_s  in  1  write-back select: 0 = ALU_Out, 1 = Mem_Out.
- RF_W_en  in  1  register-file write enable.
- RF_W_addr  in  RF_AW  write register.
- RF_Ra_addr  in  RF_AW  read port A register.
- RF_Rb_addr  in  RF_AW  read port B register.
- Alu_s0  in  3  ALU operation select.
- Ra_data  out  DATA_W  register-file port A value (combinational).
- Rb_data  out  DATA_W  register-file port B value (combinational).
- ALU_Out  out  DATA_W  ALU result (combinational).
- Mem_Out  out  DATA_W  data-memory word at D_Addr (combinational).
- Zero  out  1  registered: last ALU write-back result was 0.
- Ovf  out  1  registered: last ADD/SUB write-back overflowed (signed).

Behaviour:

Reset (asynchronous, Reset=1):
- All 16 registers = 0.
- Zero = 0, Ovf = 0.
- Data memory contents are NOT reset; they retain their values.
- While Reset=1, writes to RF, memory and flags are suppressed.

Register file:
- Reads are combinational.
- Write occurs on rising Clk when RF_W_en=1: RF[RF_W_addr] <= RF_s ? Mem_Out : ALU_Out.
- No write bypass: a read of RF_W_addr in the same cycle returns the old value; the new value is visible after the edge.
- R0 is an ordinary register (not hardwired to 0).

Data memory:
- Mem_Out = M[D_Addr] combinationally.
- On rising Clk with D_Wr=1: M[D_Addr] <= Ra_data.
- Same-cycle read of the written address returns the old word.

ALU (A=Ra_data, B=Rb_data), results mod 2^16:

| Alu_s0 | Result |
|---|---|
| 000 | 0 |
| 001 | A+B |
| 010 | A-B |
| 011 | A |
| 100 | A^B |
| 101 | A\|B |
| 110 | A&B |
| 111 | A+1 |

Flags:
- Update only on rising Clk with RF_W_en=1 and RF_s=0; otherwise hold.
- Zero <= (ALU_Out == 0).
- Ovf <= signed overflow for 001, 010 and 111; Ovf <= 0 for all other ops.

Simultaneous events:
- D_Wr=1 and RF_W_en=1 in the same cycle: both writes occur.
- With RF_s=1 in that cycle, RF receives the old memory word and memory receives Ra_data.

Latency:
- Combinational outputs settle within the cycle.
- State is visible 1 cycle after the enabling edge.

Control-word protocol:
- No handshake.
- The control unit holds the control word stable for one full cycle per operation.

Reset mid-operation:
- An asserted Reset overrides any pending write at that edge.
- Memory is unchanged by Reset.

Test Plan:
1. Reset, then read all 16 registers via RF_Ra_addr sweep -> Ra_data = 0x0000 each; Zero = 0, Ovf = 0.
2. Seed and load:
   - Write memory directly via STORE path: set R1 (M[5]=0x0007 preloaded by bench backdoor).
   - LOAD: D_Addr=5, RF_s=1, RF_W_en=1, RF_W_addr=1.
   - Next cycle RF_Ra_addr=1 -> Ra_data = 0x0007; flags unchanged.
3. ADD/SUB:
   - R1=0x0007, R2=0x0003, Alu_s0=001, RF_W_addr=3 -> R3 = 0x000A, Zero = 0.
   - Then Alu_s0=010 with Ra=Rb=R1 into R4 -> R4 = 0x0000, Zero = 1.
3a. Overflow: R5=0x7FFF, Alu_s0=111 into R6 -> R6 = 0x8000, Ovf = 1; a following Alu_s0=011 write -> Ovf = 0.
4. STORE plus simultaneous write:
   - RF_Ra_addr=3 (0x000A), D_Addr=0x20, D_Wr=1, and the same cycle RF_W_en=1, RF_s=1, RF_W_addr=7 -> R7 = old M[0x20].
   - Next cycle Mem_Out at 0x20 = 0x000A.
5. No-bypass check: RF_Ra_addr = RF_W_addr = 3 with RF_W_en=1 -> Ra_data shows old R3 during the cycle, the new value after the edge.
6. Reset mid-operation:
   - Assert Reset asynchronously mid-cycle while RF_W_en=1 and D_Wr=1 -> registers = 0 immediately, flags = 0.
   - The M[D_Addr] value equals its pre-reset value.

Source files
------------

// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
// Execution stage fed by the processor control unit. It holds a register file
// with two combinational read ports and one synchronous write port, a
// combinational ALU, and a data memory with combinational read and synchronous
// write. A 2:1 mux picks the register write-back source (ALU or memory).
// Zero/Ovf are registered status flags reserved for future branch support.
//
// Ports
//   Clk         in   system clock, all state updates on the rising edge
//   Reset       in   asynchronous active-high reset (RF and flags only)
//   D_Addr      in   data-memory address
//   D_Wr        in   data-memory write enable (stores Ra_data)
//   RF_s        in   write-back select: 0 = ALU_Out, 1 = Mem_Out
//   RF_W_en     in   register-file write enable
//   RF_W_addr   in   register-file write address
//   RF_Ra_addr  in   read port A address
//   RF_Rb_addr  in   read port B address
//   Alu_s0      in   ALU operation select
//   Ra_data     out  read port A value (combinational)
//   Rb_data     out  read port B value (combinational)
//   ALU_Out     out  ALU result (combinational)
//   Mem_Out     out  data-memory word at D_Addr (combinational)
//   Zero        out  registered: last ALU write-back result was zero
//   Ovf         out  registered: last ADD/SUB/INC write-back overflowed
// -----------------------------------------------------------------------------
module datapath #(
    parameter int DATA_W = 16,
    parameter int RF_AW  = 4,
    parameter int DM_AW  = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DM_AW-1:0]  D_Addr,
    input  logic              D_Wr,
    input  logic              RF_s,
    input  logic              RF_W_en,
    input  logic [RF_AW-1:0]  RF_W_addr,
    input  logic [RF_AW-1:0]  RF_Ra_addr,
    input  logic [RF_AW-1:0]  RF_Rb_addr,
    input  logic [2:0]        Alu_s0,
    output logic [DATA_W-1:0] Ra_data,
    output logic [DATA_W-1:0] Rb_data,
    output logic [DATA_W-1:0] ALU_Out,
    output logic [DATA_W-1:0] Mem_Out,
    output logic              Zero,
    output logic              Ovf
);

    localparam int RF_N = 1 << RF_AW;
    localparam int DM_N = 1 << DM_AW;
    localparam logic [DATA_W-1:0] ONE_C = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ALU_ZERO = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_PASS = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_AND  = 3'b110,
        ALU_INC  = 3'b111
    } alu_op_e;

    // Signed overflow of r = a + b: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic [DATA_W-1:0] r);
        return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    // Signed overflow of r = a - b: operands differ in sign, result sign
    // differs from the minuend.
    function automatic logic sub_ovf(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic [DATA_W-1:0] r);
        return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    logic [DATA_W-1:0] rf_q [RF_N];
    logic [DATA_W-1:0] mem_q [DM_N];
    logic              zero_q;
    logic              zero_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_ovf_s;
    logic [DATA_W-1:0] wb_data_s;
    alu_op_e           alu_op_s;

    assign Ra_data   = rf_q[RF_Ra_addr];
    assign Rb_data   = rf_q[RF_Rb_addr];
    assign Mem_Out   = mem_q[D_Addr];
    assign ALU_Out   = alu_res_s;
    assign Zero      = zero_q;
    assign Ovf       = ovf_q;
    assign alu_op_s  = alu_op_e'(Alu_s0);
    // Memory read is taken before this edge's store lands, so a simultaneous
    // load + store returns the old word.
    assign wb_data_s = RF_s ? Mem_Out : alu_res_s;

    // ALU result and its signed-overflow indication.
    always_comb begin
        alu_res_s = '0;
        alu_ovf_s = 1'b0;
        case (alu_op_s)
            ALU_ZERO: begin
                alu_res_s = '0;
            end
            ALU_ADD: begin
                alu_res_s = Ra_data + Rb_data;
                alu_ovf_s = add_ovf(Ra_data, Rb_data, alu_res_s);
            end
            ALU_SUB: begin
                alu_res_s = Ra_data - Rb_data;
                alu_ovf_s = sub_ovf(Ra_data, Rb_data, alu_res_s);
            end
            ALU_PASS: begin
                alu_res_s = Ra_data;
            end
            ALU_XOR: begin
                alu_res_s = Ra_data ^ Rb_data;
            end
            ALU_OR: begin
                alu_res_s = Ra_data | Rb_data;
            end
            ALU_AND: begin
                alu_res_s = Ra_data & Rb_data;
            end
            ALU_INC: begin
                alu_res_s = Ra_data + ONE_C;
                alu_ovf_s = add_ovf(Ra_data, ONE_C, alu_res_s);
            end
            default: begin
                alu_res_s = '0;
                alu_ovf_s = 1'b0;
            end
        endcase
    end

    // Flags follow only ALU write-backs; loads and idle cycles hold them.
    always_comb begin
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (RF_W_en && !RF_s) begin
            zero_d = (alu_res_s == '0);
            ovf_d  = alu_ovf_s;
        end else begin
            zero_d = zero_q;
            ovf_d  = ovf_q;
        end
    end

    // Status flag registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    // Register file write port; R0 is an ordinary register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < RF_N; i++) begin
                rf_q[i] <= '0;
            end
        end else if (RF_W_en) begin
            rf_q[RF_W_addr] <= wb_data_s;
        end
    end

    // Data memory store port; contents survive Reset but no store happens
    // while Reset is held.
    always_ff @(posedge Clk) begin
        if (D_Wr && !Reset) begin
            mem_q[D_Addr] <= Ra_data;
        end
    end

endmodule

// File: tb/tb_datapath.sv
`timescale 1ns/1ps
module tb_datapath;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic        RF_W_en;
    logic [3:0]  RF_W_addr;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  Alu_s0;
    logic [15:0] Ra_data;
    logic [15:0] Rb_data;
    logic [15:0] ALU_Out;
    logic [15:0] Mem_Out;
    logic        Zero;
    logic        Ovf;

    datapath #(.DATA_W(16), .RF_AW(4), .DM_AW(8)) dut (
        .Clk(Clk), .Reset(Reset), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
        .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr),
        .RF_Rb_addr(RF_Rb_addr), .Alu_s0(Alu_s0), .Ra_data(Ra_data),
        .Rb_data(Rb_data), .ALU_Out(ALU_Out), .Mem_Out(Mem_Out),
        .Zero(Zero), .Ovf(Ovf)
    );

    always #5 Clk = ~Clk;

    // Reference state
    logic [15:0] rf_m [16];
    logic [15:0] mem_m [256];
    logic        zero_m;
    logic        ovf_m;
    bit          mem_valid;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU: plain integer arithmetic, overflow from signed range.
    function automatic void ref_alu(input logic [2:0] op, input logic [15:0] a,
                                    input logic [15:0] b, output logic [15:0] r,
                                    output bit ov);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = 0;
        ov = 1'b0;
        case (op)
            3'd0: r = 16'h0000;
            3'd1: begin s = sa + sb; r = 16'(s); ov = (s > 32767) || (s < -32768); end
            3'd2: begin s = sa - sb; r = 16'(s); ov = (s > 32767) || (s < -32768); end
            3'd3: r = a;
            3'd4: r = a ^ b;
            3'd5: r = a | b;
            3'd6: r = a & b;
            default: begin s = sa + 1; r = 16'(s); ov = (s > 32767); end
        endcase
    endfunction

    // One operation: entered at posedge+1, leaves at next posedge+1.
    task automatic cycle(input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] op,
                         input logic wen, input logic [3:0] wa, input logic rfs,
                         input logic dwr, input logic [7:0] da);
        logic [15:0] r, wb, a_old;
        bit ov;
        RF_Ra_addr = ra; RF_Rb_addr = rb; Alu_s0 = op; RF_W_en = wen;
        RF_W_addr = wa; RF_s = rfs; D_Wr = dwr; D_Addr = da;
        #3;
        ref_alu(op, rf_m[ra], rf_m[rb], r, ov);
        check_val("ra_data", Ra_data, rf_m[ra]);
        check_val("rb_data", Rb_data, rf_m[rb]);
        check_val("alu_out", ALU_Out, r);
        if (mem_valid) check_val("mem_out", Mem_Out, mem_m[da]);
        wb    = rfs ? mem_m[da] : r;
        a_old = rf_m[ra];
        @(posedge Clk);
        if (dwr) mem_m[da] = a_old;
        if (wen) rf_m[wa] = wb;
        if (wen && !rfs) begin
            zero_m = (r == 16'h0000);
            ovf_m  = ov;
        end
        #1;
        check_val("zero", {15'd0, Zero}, {15'd0, zero_m});
        check_val("ovf", {15'd0, Ovf}, {15'd0, ovf_m});
    endtask

    // Look at a register / memory word with writes disabled.
    task automatic peek(input string tag, input logic [3:0] ra, input logic [7:0] da,
                        input logic [15:0] exp_r, input logic [15:0] exp_m);
        RF_W_en = 1'b0; D_Wr = 1'b0; RF_Ra_addr = ra; D_Addr = da;
        #1;
        check_val({tag, "_reg"}, Ra_data, exp_r);
        check_val({tag, "_mem"}, Mem_Out, exp_m);
    endtask

    // Async reset asserted mid-cycle with writes pending.
    task automatic mid_reset(input logic [3:0] ra, input logic [7:0] da);
        logic [15:0] m_before;
        m_before = mem_m[da];
        RF_Ra_addr = ra; RF_Rb_addr = ra; Alu_s0 = 3'd7; RF_W_en = 1'b1;
        RF_W_addr = ra; RF_s = 1'b0; D_Wr = 1'b1; D_Addr = da;
        #2;
        Reset = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) rf_m[i] = 16'h0000;
        zero_m = 1'b0;
        ovf_m  = 1'b0;
        check_val("rst_zero", {15'd0, Zero}, 16'h0000);
        check_val("rst_ovf", {15'd0, Ovf}, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            RF_Ra_addr = 4'(i);
            #1;
            check_val("rst_reg", Ra_data, 16'h0000);
        end
        @(negedge Clk);
        check_val("rst_mem_kept", Mem_Out, m_before);
        RF_W_en = 1'b0; D_Wr = 1'b0;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; D_Addr = 8'd0; D_Wr = 1'b0; RF_s = 1'b0; RF_W_en = 1'b0;
        RF_W_addr = 4'd0; RF_Ra_addr = 4'd0; RF_Rb_addr = 4'd0; Alu_s0 = 3'd0;
        for (int i = 0; i < 16; i++) rf_m[i] = 16'h0000;
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
        zero_m = 1'b0; ovf_m = 1'b0; mem_valid = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // 1. reset state
        check_val("init_zero", {15'd0, Zero}, 16'h0000);
        check_val("init_ovf", {15'd0, Ovf}, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            RF_Ra_addr = 4'(i);
            #0.5;
            check_val("init_reg", Ra_data, 16'h0000);
        end
        @(posedge Clk);
        #1;

        // Clear the whole memory by storing R0 (= 0) everywhere.
        for (int i = 0; i < 256; i++) cycle(4'd0, 4'd0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'(i));
        mem_valid = 1'b1;

        // 2. build 7 in R0, store to M[5], load into R1
        repeat (7) cycle(4'd0, 4'd0, 3'd7, 1'b1, 4'd0, 1'b0, 1'b0, 8'd0);
        cycle(4'd0, 4'd0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'd5);
        cycle(4'd0, 4'd0, 3'd0, 1'b1, 4'd1, 1'b1, 1'b0, 8'd5);
        peek("load_r1", 4'd1, 8'd5, 16'h0007, 16'h0007);
        @(posedge Clk); #1;

        // 3. R2 = 3, ADD into R3, SUB R1-R1 into R4
        cycle(4'd0, 4'd0, 3'd0, 1'b1, 4'd2, 1'b0, 1'b0, 8'd0);
        check_val("zero_after_clr", {15'd0, Zero}, 16'h0001);
        repeat (3) cycle(4'd2, 4'd0, 3'd7, 1'b1, 4'd2, 1'b0, 1'b0, 8'd0);
        cycle(4'd1, 4'd2, 3'd1, 1'b1, 4'd3, 1'b0, 1'b0, 8'd0);
        check_val("add_zero", {15'd0, Zero}, 16'h0000);
        cycle(4'd1, 4'd1, 3'd2, 1'b1, 4'd4, 1'b0, 1'b0, 8'd0);
        check_val("sub_zero", {15'd0, Zero}, 16'h0001);
        peek("r3_add", 4'd3, 8'd0, 16'h000A, 16'h0000);
        @(posedge Clk); #1;

        // 3a. R9 = 1, R8 = 0x8000 by doubling, R5 = 0x7FFF, INC into R6
        cycle(4'd0, 4'd0, 3'd0, 1'b1, 4'd9, 1'b0, 1'b0, 8'd0);
        cycle(4'd9, 4'd0, 3'd7, 1'b1, 4'd9, 1'b0, 1'b0, 8'd0);
        cycle(4'd9, 4'd0, 3'd3, 1'b1, 4'd8, 1'b0, 1'b0, 8'd0);
        repeat (15) cycle(4'd8, 4'd8, 3'd1, 1'b1, 4'd8, 1'b0, 1'b0, 8'd0);
        cycle(4'd8, 4'd9, 3'd2, 1'b1, 4'd5, 1'b0, 1'b0, 8'd0);
        cycle(4'd5, 4'd0, 3'd7, 1'b1, 4'd6, 1'b0, 1'b0, 8'd0);
        check_val("inc_ovf", {15'd0, Ovf}, 16'h0001);
        cycle(4'd5, 4'd0, 3'd3, 1'b1, 4'd10, 1'b0, 1'b0, 8'd0);
        check_val("pass_ovf", {15'd0, Ovf}, 16'h0000);
        peek("r6_inc", 4'd6, 8'd0, 16'h8000, 16'h0000);
        @(posedge Clk); #1;

        // 4. store R3 to M[0x20] while loading old M[0x20] into R7
        cycle(4'd3, 4'd0, 3'd0, 1'b1, 4'd7, 1'b1, 1'b1, 8'h20);
        peek("st_ld", 4'd7, 8'h20, 16'h0000, 16'h000A);
        @(posedge Clk); #1;

        // 5. no bypass: R3 = R3 + R3 reading and writing R3
        cycle(4'd3, 4'd3, 3'd1, 1'b1, 4'd3, 1'b0, 1'b0, 8'd0);
        peek("no_bypass", 4'd3, 8'h20, 16'h0014, 16'h000A);
        @(posedge Clk); #1;

        // 6. reset mid operation
        mid_reset(4'd3, 8'h20);

        // Randomized operation mix
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end else begin
                cycle(4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
                      4'($urandom), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 31)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
